// File: rtl/nway_mux_skid_if.sv
// Handshake bundle for nway_mux_skid: producer side (packed inputs, select, flush)
// and consumer side (registered selected beat with error flag).
interface nway_mux_skid_if #(
  parameter int N_INPUTS  = 3,
  parameter int BIT_WIDTH = 32
);
  localparam int SEL_W = $clog2(N_INPUTS);

  logic [N_INPUTS*BIT_WIDTH-1:0] in_data;
  logic [SEL_W-1:0]              in_sel;
  logic                          in_valid;
  logic                          in_ready;
  logic                          flush;
  logic [BIT_WIDTH-1:0]          out_data;
  logic                          out_err;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/nway_mux_skid.sv
// N:1 select into a main+skid output stage; 1-cycle latency from EMPTY, 1 beat/cycle sustained.
// in_ready is registered and drops one cycle after a stalled accept; flush discards everything held.
module nway_mux_skid #(
  parameter int N_INPUTS  = 3,
  parameter int BIT_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  nway_mux_skid_if.slave bus
);
  localparam int SEL_W = $clog2(N_INPUTS);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t               state, state_nxt;
  logic [BIT_WIDTH-1:0] main_dat, main_dat_nxt;
  logic                 main_err, main_err_nxt;
  logic [BIT_WIDTH-1:0] skid_dat, skid_dat_nxt;
  logic                 skid_err, skid_err_nxt;
  logic                 rdy_q;
  logic [BIT_WIDTH-1:0] sel_dat;
  logic                 sel_err;
  logic                 accept;
  logic                 deliver;

  // Codes with no matching input (including unused codes for non-power-of-2 N) fall through as error.
  always_comb begin
    sel_dat = '0;
    sel_err = 1'b1;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (bus.in_sel == SEL_W'(i)) begin
        sel_dat = bus.in_data[i*BIT_WIDTH +: BIT_WIDTH];
        sel_err = 1'b0;
      end
    end
  end

  assign accept  = bus.in_valid & rdy_q;
  assign deliver = (state != EMPTY) & bus.out_ready;

  always_comb begin
    state_nxt    = state;
    main_dat_nxt = main_dat;
    main_err_nxt = main_err;
    skid_dat_nxt = skid_dat;
    skid_err_nxt = skid_err;
    if (bus.flush) begin
      state_nxt    = EMPTY;
      main_dat_nxt = '0;
      main_err_nxt = 1'b0;
      skid_dat_nxt = '0;
      skid_err_nxt = 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            main_dat_nxt = sel_dat;
            main_err_nxt = sel_err;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_dat_nxt = sel_dat;
            main_err_nxt = sel_err;
          end else if (accept) begin
            state_nxt    = FULL;
            skid_dat_nxt = sel_dat;
            skid_err_nxt = sel_err;
          end else if (deliver) begin
            state_nxt    = EMPTY;
            main_dat_nxt = '0;
            main_err_nxt = 1'b0;
          end
        end
        FULL: begin
          if (deliver) begin
            state_nxt    = ONE;
            main_dat_nxt = skid_dat;
            main_err_nxt = skid_err;
            skid_dat_nxt = '0;
            skid_err_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt    = EMPTY;
          main_dat_nxt = '0;
          main_err_nxt = 1'b0;
          skid_dat_nxt = '0;
          skid_err_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      main_dat <= '0;
      main_err <= 1'b0;
      skid_dat <= '0;
      skid_err <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state    <= state_nxt;
      main_dat <= main_dat_nxt;
      main_err <= main_err_nxt;
      skid_dat <= skid_dat_nxt;
      skid_err <= skid_err_nxt;
      rdy_q    <= (state_nxt != FULL);
    end
  end

  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = main_dat;
  assign bus.out_err   = main_err;
  assign bus.in_ready  = rdy_q;
endmodule
